spram_arb_ctrl: RTL and testbench

SPRAM_ARB_CTRL -- requirements
Module: spram_arb_ctrl

---
 rtl/spram_arb_ctrl.sv | 151 +++++++++++++++
 tb/tb_spram_arb_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spram_arb_ctrl.sv
// spram_arb_ctrl: two-port arbiter and power controller for a 16K x 32
// cascaded SPRAM pair.
//   clk, rst_n          single clock, asynchronous active-low reset
//   sleep_en            1 = idle sleep allowed
//   req/we/addr/wdata/be{0,1}   per-port requests, payload held until granted
//   gnt{0,1}            combinational grant (access issued this cycle)
//   rvalid{0,1}, rdata  read return, one cycle after the read grant
//   asleep              registered: controller is in SLEEP or WAKE
//   mem_*               SPRAM pair controls; mem_dout is the read data back
module spram_arb_ctrl #(
  parameter int IDLE_LIMIT  = 64,  // 1..255
  parameter int WAKE_CYCLES = 3    // 1..15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sleep_en,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [13:0] addr0,
  input  logic [13:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  input  logic [3:0]  be0,
  input  logic [3:0]  be1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [31:0] rdata,
  output logic        asleep,
  output logic [13:0] mem_addr,
  output logic [31:0] mem_din,
  output logic [7:0]  mem_mask,
  output logic        mem_wren,
  output logic        mem_cs,
  output logic        mem_standby,
  output logic        mem_sleep,
  output logic        mem_poweroff,
  input  logic [31:0] mem_dout
);

  localparam logic [7:0] IDLE_MAX  = 8'(IDLE_LIMIT);
  localparam logic [7:0] IDLE_TRIG = 8'(IDLE_LIMIT - 1);
  localparam logic [3:0] WAKE_LAST = 4'(WAKE_CYCLES - 1);

  typedef enum logic [1:0] {ACTIVE, SLEEP, WAKE} state_t;

  typedef struct packed {
    logic        we;
    logic [13:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } acc_t;

  state_t      state, state_nxt;
  logic [7:0]  idle_cnt, idle_cnt_nxt;
  logic [3:0]  wake_cnt, wake_cnt_nxt;
  logic        last_gnt;
  logic [1:0]  req, gnt_raw, gnt;
  acc_t [1:0]  acc;
  acc_t        sel;
  logic [7:0]  mask_exp;
  logic        issue;

  assign req    = {req1, req0};
  assign acc[0] = {we0, addr0, wdata0, be0};
  assign acc[1] = {we1, addr1, wdata1, be1};

  always_comb begin
    state_nxt    = state;
    idle_cnt_nxt = idle_cnt;
    wake_cnt_nxt = wake_cnt;
    gnt_raw      = 2'b00;
    case (state)
      ACTIVE: begin
        // Under contention the port that did not win last time goes.
        if (&req) gnt_raw = last_gnt ? 2'b01 : 2'b10;
        else      gnt_raw = req;
        if (|req) begin
          idle_cnt_nxt = '0;
        end else if (sleep_en && idle_cnt == IDLE_TRIG) begin
          state_nxt    = SLEEP;
          idle_cnt_nxt = '0;
        end else if (idle_cnt != IDLE_MAX) begin
          idle_cnt_nxt = idle_cnt + 8'd1;
        end
      end
      SLEEP: begin
        if ((|req) || !sleep_en) begin
          state_nxt    = WAKE;
          wake_cnt_nxt = '0;
        end
      end
      WAKE: begin
        if (wake_cnt == WAKE_LAST) begin
          state_nxt    = ACTIVE;
          wake_cnt_nxt = '0;
        end else begin
          wake_cnt_nxt = wake_cnt + 4'd1;
        end
      end
      default: state_nxt = ACTIVE;
    endcase
  end

  // Grants are combinational; gating with rst_n keeps the memory quiet
  // while reset is held even if requests are already up.
  assign gnt   = gnt_raw & {2{rst_n}};
  assign gnt0  = gnt[0];
  assign gnt1  = gnt[1];
  assign issue = |gnt;
  assign sel   = gnt[1] ? acc[1] : acc[0];

  // Each byte enable covers two nibble-mask bits of the SPRAM pair.
  for (genvar b = 0; b < 4; b++) begin : g_mask
    assign mask_exp[2*b +: 2] = {2{sel.be[b]}};
  end

  assign mem_cs       = issue;
  assign mem_wren     = issue & sel.we;
  assign mem_addr     = sel.addr;
  assign mem_din      = sel.wdata;
  assign mem_mask     = (issue & sel.we) ? mask_exp : 8'h00;
  assign mem_sleep    = (state == SLEEP);
  assign mem_standby  = 1'b0;
  assign mem_poweroff = 1'b1;
  assign rdata        = mem_dout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ACTIVE;
      idle_cnt <= '0;
      wake_cnt <= '0;
      last_gnt <= 1'b1;
      rvalid0  <= 1'b0;
      rvalid1  <= 1'b0;
      asleep   <= 1'b0;
    end else begin
      state    <= state_nxt;
      idle_cnt <= idle_cnt_nxt;
      wake_cnt <= wake_cnt_nxt;
      if (issue) last_gnt <= gnt[1];
      rvalid0  <= gnt[0] & ~we0;
      rvalid1  <= gnt[1] & ~we1;
      asleep   <= (state_nxt != ACTIVE);
    end
  end

endmodule

// File: tb/tb_spram_arb_ctrl.sv
// Bench for spram_arb_ctrl: directed scenarios plus random traffic, checked
// every cycle against a transaction-level reference model and a byte-wise
// reference memory. A simple SPRAM model answers the DUT's memory port.
module tb_spram_arb_ctrl;
  localparam int IDLE_LIMIT  = 64;
  localparam int WAKE_CYCLES = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        sleep_en = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [1:0]  we = 2'b00;
  logic [13:0] addr [2];
  logic [31:0] wdata [2];
  logic [3:0]  be [2];

  logic        gnt0, gnt1, rvalid0, rvalid1, asleep;
  logic [31:0] rdata, mem_din, mem_dout;
  logic [13:0] mem_addr;
  logic [7:0]  mem_mask;
  logic        mem_wren, mem_cs, mem_standby, mem_sleep, mem_poweroff;

  spram_arb_ctrl #(.IDLE_LIMIT(IDLE_LIMIT), .WAKE_CYCLES(WAKE_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n), .sleep_en(sleep_en),
    .req0(req[0]), .req1(req[1]), .we0(we[0]), .we1(we[1]),
    .addr0(addr[0]), .addr1(addr[1]), .wdata0(wdata[0]), .wdata1(wdata[1]),
    .be0(be[0]), .be1(be[1]),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .asleep(asleep),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_mask(mem_mask),
    .mem_wren(mem_wren), .mem_cs(mem_cs), .mem_standby(mem_standby),
    .mem_sleep(mem_sleep), .mem_poweroff(mem_poweroff), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // SPRAM pair: nibble-masked writes, registered read data.
  logic [31:0] spram [0:16383];
  logic [31:0] ref_mem [0:16383];
  logic [31:0] nw;
  always @(posedge clk) begin
    if (mem_cs) begin
      if (mem_wren) begin
        nw = spram[mem_addr];
        for (int k = 0; k < 8; k++) if (mem_mask[k]) nw[4*k +: 4] = mem_din[4*k +: 4];
        spram[mem_addr] <= nw;
      end else begin
        mem_dout <= spram[mem_addr];
      end
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  bit          m_sleep;   // memory asleep
  int          m_wake;    // wake cycles still to go
  int          m_idle;    // consecutive idle cycles while serving
  int          m_last;    // port granted most recently
  bit [1:0]    m_rdv;     // read return due this cycle, per port
  logic [31:0] m_rdat;
  int          m_w;       // port granted in the last modelled cycle, -1 none
  bit [1:0]    refill;

  logic [1:0]  o_gnt, o_rv;
  logic [7:0]  o_mask;
  logic [31:0] o_rdata;
  logic        o_asleep;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] nib_mask(logic [3:0] b);
    logic [7:0] m;
    for (int i = 0; i < 4; i++) m[2*i +: 2] = {2{b[i]}};
    return m;
  endfunction

  task automatic set_req(int p, logic w, logic [13:0] a, logic [31:0] d, logic [3:0] b);
    req[p] = 1'b1; we[p] = w; addr[p] = a; wdata[p] = d; be[p] = b;
  endtask

  task automatic new_req(int p);
    set_req(p, 1'($urandom_range(0, 1)), 14'($urandom_range(0, 15)), $urandom,
            4'($urandom_range(0, 15)));
  endtask

  task automatic model_reset();
    m_sleep = 0; m_wake = 0; m_idle = 0; m_last = 1; m_rdv = 2'b00; m_w = -1;
  endtask

  // One clock: check outputs mid-cycle, step the model, then retire grants.
  task automatic cycle();
    bit          act;
    int          w;
    logic [7:0]  xm;
    logic [31:0] nd;
    @(negedge clk);
    act = !m_sleep && m_wake == 0;
    w = -1;
    if (act) begin
      if (req[0] && req[1]) w = (m_last == 1) ? 0 : 1;
      else if (req[0])      w = 0;
      else if (req[1])      w = 1;
    end
    o_gnt = {gnt1, gnt0}; o_mask = mem_mask; o_rdata = rdata;
    o_rv = {rvalid1, rvalid0}; o_asleep = asleep;
    chk("gnt0", 32'(gnt0), 32'(w == 0));
    chk("gnt1", 32'(gnt1), 32'(w == 1));
    chk("mem_cs", 32'(mem_cs), 32'(w >= 0));
    xm = (w >= 0 && we[w]) ? nib_mask(be[w]) : 8'h00;
    chk("mem_mask", 32'(mem_mask), 32'(xm));
    chk("mem_wren", 32'(mem_wren), 32'(w >= 0 && we[w]));
    if (w >= 0) begin
      chk("mem_addr", 32'(mem_addr), 32'(addr[w]));
      if (we[w]) chk("mem_din", mem_din, wdata[w]);
    end
    chk("mem_sleep", 32'(mem_sleep), 32'(m_sleep));
    chk("asleep", 32'(asleep), 32'(!act));
    chk("rvalid0", 32'(rvalid0), 32'(m_rdv[0]));
    chk("rvalid1", 32'(rvalid1), 32'(m_rdv[1]));
    if (m_rdv != 2'b00) chk("rdata", rdata, m_rdat);

    m_rdv = 2'b00;
    if (w >= 0) begin
      m_last = w;
      if (we[w]) begin
        nd = ref_mem[addr[w]];
        for (int b = 0; b < 4; b++) if (be[w][b]) nd[8*b +: 8] = wdata[w][8*b +: 8];
        ref_mem[addr[w]] = nd;
      end else begin
        m_rdv[w] = 1'b1;
        m_rdat   = ref_mem[addr[w]];
      end
    end
    if (act) begin
      if (|req) m_idle = 0;
      else begin
        m_idle++;
        if (sleep_en && m_idle == IDLE_LIMIT) begin m_sleep = 1; m_idle = 0; end
      end
    end else if (m_sleep) begin
      if ((|req) || !sleep_en) begin m_sleep = 0; m_wake = WAKE_CYCLES; end
    end else begin
      m_wake--;
    end
    m_w = w;
    @(posedge clk); #1;
    if (w >= 0) begin
      if (refill[w]) new_req(w);
      else req[w] = 1'b0;
    end
  endtask

  task automatic wait_gnt(int p);
    int n = 0;
    do begin cycle(); n++; end while (m_w != p && n < 100);
    chk("wait_gnt", 32'(m_w), 32'(p));
  endtask

  // Called just after a rising edge; holds reset across one edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_rv0", 32'(rvalid0), 32'd0);
    chk("rst_rv1", 32'(rvalid1), 32'd0);
    chk("rst_asleep", 32'(asleep), 32'd0);
    chk("rst_gnt", 32'({gnt1, gnt0}), 32'd0);
    chk("rst_cs", 32'(mem_cs), 32'd0);
    chk("rst_wren", 32'(mem_wren), 32'd0);
    chk("rst_mask", 32'(mem_mask), 32'd0);
    chk("rst_sleep", 32'(mem_sleep), 32'd0);
    chk("standby", 32'(mem_standby), 32'd0);
    chk("poweroff", 32'(mem_poweroff), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int n, quiet;
    for (int i = 0; i < 16384; i++) begin spram[i] = '0; ref_mem[i] = '0; end
    mem_dout = '0;
    for (int p = 0; p < 2; p++) begin addr[p] = '0; wdata[p] = '0; be[p] = '0; end
    refill = 2'b00;
    model_reset();

    // Reset with a request already pending: granted on the first cycle out.
    #2;
    set_req(1, 1'b0, 14'h3, 32'h0, 4'h0);
    do_reset();
    cycle();
    chk("first_gnt", 32'(o_gnt), 32'd2);

    // Full write, read back
    set_req(0, 1'b1, 14'h10, 32'hDEADBEEF, 4'hF); wait_gnt(0);
    set_req(0, 1'b0, 14'h10, 32'h0, 4'h0);        wait_gnt(0);
    cycle();
    chk("rd_full_rv", 32'(o_rv), 32'd1);
    chk("rd_full", o_rdata, 32'hDEADBEEF);

    // Single-byte write
    set_req(0, 1'b1, 14'h10, 32'h0000AB00, 4'h2); wait_gnt(0);
    chk("mask_b1", 32'(o_mask), 32'h0C);
    // Write with no byte enables changes nothing
    set_req(1, 1'b1, 14'h10, 32'hFFFFFFFF, 4'h0); wait_gnt(1);
    chk("mask_be0", 32'(o_mask), 32'h00);
    set_req(0, 1'b0, 14'h10, 32'h0, 4'h0);        wait_gnt(0);
    cycle();
    chk("rd_merge", o_rdata, 32'hDEADABEF);

    // Continuous contention after reset alternates starting at port 0
    do_reset();
    refill = 2'b11; new_req(0); new_req(1);
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("alt", 32'(o_gnt), (i % 2 == 1) ? 32'd2 : 32'd1);
    end
    refill = 2'b00;
    sleep_en = 1'b1;
    for (int i = 0; i < 4 && (|req); i++) cycle();

    // Idle into sleep, then wake on a port 1 read
    repeat (IDLE_LIMIT) cycle();
    cycle();
    chk("slept", 32'(o_asleep), 32'd1);
    chk("mem_slept", 32'(mem_sleep), 32'd1);
    set_req(1, 1'b0, 14'h10, 32'h0, 4'h0);
    n = 0;
    do begin cycle(); n++; end while (m_w != 1 && n < 20);
    chk("wake_lat", 32'(n), 32'(WAKE_CYCLES + 2));
    cycle();
    chk("wake_rv", 32'(o_rv), 32'd2);
    chk("wake_rd", o_rdata, 32'hDEADABEF);

    // Request on the last idle cycle wins over sleep entry
    repeat (IDLE_LIMIT - 2) cycle();
    set_req(0, 1'b1, 14'h20, 32'h12345678, 4'hF);
    cycle();
    chk("edge_gnt", 32'(o_gnt), 32'd1);
    chk("edge_awake", 32'(o_asleep), 32'd0);
    sleep_en = 1'b0;
    repeat (300) cycle();
    chk("no_sleep", 32'(o_asleep), 32'd0);

    // Reset between read grant and read return
    sleep_en = 1'b1;
    set_req(0, 1'b0, 14'h20, 32'h0, 4'h0);
    wait_gnt(0);
    do_reset();
    set_req(0, 1'b1, 14'h21, 32'h1, 4'hF);
    set_req(1, 1'b1, 14'h22, 32'h2, 4'hF);
    cycle();
    chk("post_rst_pri", 32'(o_gnt), 32'd1);
    chk("post_rst_act", 32'(o_asleep), 32'd0);
    cycle();

    // Random traffic with idle bursts and sleep_en toggling
    quiet = 0;
    for (int i = 0; i < 2500; i++) begin
      if (i == 1200) do_reset();
      if (quiet > 0) quiet--;
      else begin
        if ($urandom_range(0, 149) == 0) quiet = 90;
        for (int p = 0; p < 2; p++)
          if (!req[p] && $urandom_range(0, 2) == 0) new_req(p);
      end
      if ($urandom_range(0, 59) == 0) sleep_en = ~sleep_en;
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
